// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Holds the FSM state encoding, the default operand width and the counter-width helper.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_N = 4;

    // The bit counter must reach N without wrapping, hence N+1 codes.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_addsub_full_adder.sv
// Single-bit full adder cell used by the serial datapath.
// Purely combinational: sum bit and majority carry.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor, LSB first, one bit per clock, done pulse after N edges.
// Optional signed overflow flag is built only when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         load,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic          sub_reg;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          bit_s;
    logic          bit_c;

    // Subtraction is a + ~b + 1: invert b per bit here, the +1 comes from carry seeded with sub.
    full_adder u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0] ^ sub_reg),
        .cin  (carry),
        .s    (bit_s),
        .cout (bit_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            sub_reg <= 1'b0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        sub_reg <= sub;
                        carry   <= sub;
                        cnt     <= '0;
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        done    <= 1'b0;
                    end
                end
                SHIFT: begin
                    sum   <= {bit_s, sum[N-1:1]};
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    carry <= bit_c;
                    cnt   <= cnt + 1'b1;
                    // On the last bit, carry still holds the carry into bit N-1.
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= bit_c;
`ifdef SERIAL_ADDSUB_OVF_EN
                        ovf   <= carry ^ bit_c;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifndef SERIAL_ADDSUB_OVF_EN
    assign ovf = 1'b0;
`endif

endmodule
